// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel colour type and the sprite palette.
package vga_pkg;

  localparam int H_ACT_START = 144;
  localparam int V_ACT_START = 35;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic {
    INC = 1'b0,
    DEC = 1'b1
  } axis_state_t;

  localparam rgb_t PALETTE [8] = '{
    12'hFFF, 12'hF00, 12'h0F0, 12'hFF0,
    12'h0FF, 12'hF0F, 12'hF80, 12'h8F8
  };

  localparam rgb_t BG_COLOR = 12'h004;

endpackage

// File: rtl/bounce_renderer_if.sv
// Video timing in / registered video out bundle between sync generator and renderer.
interface bounce_renderer_if;
  logic       HSync;
  logic       VSync;
  logic       HDisplay;
  logic       VDisplay;
  logic [9:0] col;
  logic [9:0] row;
  logic       HSync_out;
  logic       VSync_out;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    output HSync, VSync, HDisplay, VDisplay, col, row,
    input  HSync_out, VSync_out, red, green, blue
  );

  modport slave (
    input  HSync, VSync, HDisplay, VDisplay, col, row,
    output HSync_out, VSync_out, red, green, blue
  );
endinterface

// File: rtl/bounce_axis.sv
// One sprite axis: ping-pongs pos between 0 and LIM in STEP increments per frame tick.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIM  = 608,
  parameter int STEP = 2,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  output logic [9:0] pos,
  output logic       bounce
);

  axis_state_t state, state_nxt;
  logic [9:0]  pos_nxt;
  logic [10:0] sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INC;
      pos   <= 10'(INIT);
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  // Extra bit on the sum keeps the wall test from wrapping near the limit.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    bounce    = 1'b0;
    sum       = {1'b0, pos} + 11'(STEP);
    if (tick && run) begin
      unique case (state)
        INC: begin
          if (sum >= 11'(LIM)) begin
            pos_nxt   = 10'(LIM);
            state_nxt = DEC;
            bounce    = 1'b1;
          end else begin
            pos_nxt = sum[9:0];
          end
        end
        DEC: begin
          if (pos <= 10'(STEP)) begin
            pos_nxt   = '0;
            state_nxt = INC;
            bounce    = 1'b1;
          end else begin
            pos_nxt = pos - 10'(STEP);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bounce_renderer.sv
// Draws a bouncing square sprite over a background, one registered stage behind the sync inputs.
module bounce_renderer
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  bounce_renderer_if.slave   vid
);

  logic [9:0]  box_x, box_y;
  logic        bounce_x, bounce_y;
  logic [2:0]  color_idx;
  logic        tick;
  logic [9:0]  px, py;
  logic [10:0] x_end, y_end;
  logic        in_box;
  rgb_t        pix_nxt;

  logic        hsync_p1;
  logic        vsync_p1;
  rgb_t        rgb_p1;

  // vsync_p1 doubles as the edge-detect history and the delayed sync output.
  assign tick = vsync_p1 & ~vid.VSync;

  bounce_axis #(.LIM(H_ACTIVE - BOX_SIZE), .STEP(STEP), .INIT(INIT_X)) u_x (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .run    (run),
    .pos    (box_x),
    .bounce (bounce_x)
  );

  bounce_axis #(.LIM(V_ACTIVE - BOX_SIZE), .STEP(STEP), .INIT(INIT_Y)) u_y (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .run    (run),
    .pos    (box_y),
    .bounce (bounce_y)
  );

  // A corner hit bounces both axes but still advances the colour once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_idx <= '0;
    end else if (bounce_x || bounce_y) begin
      color_idx <= color_idx + 3'd1;
    end
  end

  assign px    = vid.col - 10'(H_ACT_START);
  assign py    = vid.row - 10'(V_ACT_START);
  assign x_end = {1'b0, box_x} + 11'(BOX_SIZE);
  assign y_end = {1'b0, box_y} + 11'(BOX_SIZE);

  always_comb begin
    in_box  = ({1'b0, px} >= {1'b0, box_x}) && ({1'b0, px} < x_end) &&
              ({1'b0, py} >= {1'b0, box_y}) && ({1'b0, py} < y_end);
    pix_nxt = '0;
    if (vid.HDisplay && vid.VDisplay) begin
      pix_nxt = in_box ? PALETTE[color_idx] : BG_COLOR;
    end
  end

  // p1: single output stage keeps sync and colour aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      rgb_p1   <= '0;
    end else begin
      hsync_p1 <= vid.HSync;
      vsync_p1 <= vid.VSync;
      rgb_p1   <= pix_nxt;
    end
  end

  assign vid.HSync_out = hsync_p1;
  assign vid.VSync_out = vsync_p1;
  assign vid.red       = rgb_p1.r;
  assign vid.green     = rgb_p1.g;
  assign vid.blue      = rgb_p1.b;

endmodule

// File: tb/tb_bounce_renderer.sv
// Directed bench for bounce_renderer: reset, pixel latency, blanking, wall/corner bounce, freeze.
module tb_bounce_renderer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic run_c;

  always #5 clk = ~clk;

  bounce_renderer_if vif ();
  bounce_renderer_if vif_c ();

  bounce_renderer #(.BOX_SIZE(32), .STEP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .vid   (vif)
  );

  bounce_renderer #(.BOX_SIZE(32), .STEP(2), .INIT_X(606), .INIT_Y(446)) dut_c (
    .clk   (clk),
    .reset (reset),
    .run   (run_c),
    .vid   (vif_c)
  );

  typedef struct packed {
    logic hs;
    logic vs;
    rgb_t rgb;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference sprite state
  int   mx, my, mc;
  logic mdx, mdy;
  logic m_vs_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mc = 0;
    mdx = 1'b0; mdy = 1'b0;
    m_vs_prev = 1'b1;
  endtask

  // Direction 0 climbs toward lim, 1 falls toward 0; walls clamp and flip.
  task automatic model_axis(inout int p, inout logic d, input int lim, output logic b);
    b = 1'b0;
    if (d == 1'b0) begin
      if (p + 2 >= lim) begin p = lim; d = 1'b1; b = 1'b1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1'b0; b = 1'b1; end
      else p = p - 2;
    end
  endtask

  function automatic rgb_t model_rgb(input logic hd, input logic vd, input int c, input int r);
    int px, py;
    if (!(hd && vd)) return 12'h000;
    px = c - 144;
    py = r - 35;
    if (px >= mx && px < mx + 32 && py >= my && py < my + 32) return PALETTE[mc];
    return BG_COLOR;
  endfunction

  task automatic step(input logic hs, input logic vs, input logic hd, input logic vd,
                      input int c, input int r);
    exp_t e;
    logic bx, by;
    vif.HSync    = hs;
    vif.VSync    = vs;
    vif.HDisplay = hd;
    vif.VDisplay = vd;
    vif.col      = 10'(c);
    vif.row      = 10'(r);
    sb_q.push_back('{hs, vs, model_rgb(hd, vd, c, r)});
    @(posedge clk); #1;
    if (m_vs_prev && !vs && run) begin
      model_axis(mx, mdx, 608, bx);
      model_axis(my, mdy, 448, by);
      if (bx || by) mc = (mc + 1) % 8;
    end
    m_vs_prev = vs;
    e = sb_q.pop_front();
    chk("hsync_out", 32'(vif.HSync_out), 32'(e.hs));
    chk("vsync_out", 32'(vif.VSync_out), 32'(e.vs));
    chk("rgb", 32'({vif.red, vif.green, vif.blue}), 32'(e.rgb));
  endtask

  task automatic frame();
    step(1'b1, 1'b1, 1'b1, 1'b1, 144 + mx + 1, 35 + my + 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, (mx >= 40) ? 144 : 783, 35 + my + 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10, 500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 700, 501);
    step(1'b1, 1'b1, 1'b0, 1'b0, 30, 0);
  endtask

  initial begin
    int sx, sy, sc, c_before;

    reset = 1'b0;
    run   = 1'b0;
    run_c = 1'b0;
    vif.HSync = 1'b0; vif.VSync = 1'b1; vif.HDisplay = 1'b1; vif.VDisplay = 1'b1;
    vif.col = 10'd150; vif.row = 10'd40;
    vif_c.HSync = 1'b1; vif_c.VSync = 1'b1; vif_c.HDisplay = 1'b0; vif_c.VDisplay = 1'b0;
    vif_c.col = 10'd0; vif_c.row = 10'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", 32'(vif.HSync_out), 32'd1);
    chk("rst_vsync", 32'(vif.VSync_out), 32'd1);
    chk("rst_rgb", 32'({vif.red, vif.green, vif.blue}), 32'd0);
    vif.HSync = 1'b1;
    vif.HDisplay = 1'b0;
    reset = 1'b1;
    chk("rst_box_x", 32'(dut.box_x), 32'd0);
    chk("rst_box_y", 32'(dut.box_y), 32'd0);
    chk("rst_color", 32'(dut.color_idx), 32'd0);
    chk("rst_xdir", 32'(dut.u_x.state), 32'(INC));

    // Pixel latency and box edges with the sprite at the origin
    step(1'b1, 1'b1, 1'b1, 1'b1, 144, 35);
    chk("lat_pal0", 32'({vif.red, vif.green, vif.blue}), 32'(PALETTE[0]));
    step(1'b1, 1'b1, 1'b1, 1'b1, 176, 35);
    chk("lat_bg", 32'({vif.red, vif.green, vif.blue}), 32'(BG_COLOR));
    step(1'b1, 1'b1, 1'b1, 1'b1, 175, 35);
    step(1'b1, 1'b1, 1'b1, 1'b1, 160, 66);
    step(1'b1, 1'b1, 1'b1, 1'b1, 160, 67);

    // Blanking on either flag
    step(1'b1, 1'b1, 1'b0, 1'b1, 100, 35);
    chk("blank_h", 32'({vif.red, vif.green, vif.blue}), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 150, 40);

    // Run into the right wall
    run = 1'b1;
    repeat (303) frame();
    chk("x_pre_wall", 32'(dut.box_x), 32'd606);
    c_before = int'(dut.color_idx);
    frame();
    chk("x_wall", 32'(dut.box_x), 32'd608);
    chk("x_wall_dir", 32'(dut.u_x.state), 32'(DEC));
    chk("x_wall_color_step", 32'(dut.color_idx), 32'((c_before + 1) % 8));
    chk("y_model", 32'(dut.box_y), 32'(my));
    chk("color_model", 32'(dut.color_idx), 32'(mc));

    // Frozen sprite still renders and passes sync through
    run = 1'b0;
    sx = mx; sy = my; sc = mc;
    repeat (5) frame();
    chk("frz_x", 32'(dut.box_x), 32'(sx));
    chk("frz_y", 32'(dut.box_y), 32'(sy));
    chk("frz_color", 32'(dut.color_idx), 32'(sc));

    // Reset mid-frame takes effect without a clock edge
    run = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 300, 200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 300, 500);
    vif.HSync = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("amid_hsync", 32'(vif.HSync_out), 32'd1);
    chk("amid_vsync", 32'(vif.VSync_out), 32'd1);
    chk("amid_rgb", 32'({vif.red, vif.green, vif.blue}), 32'd0);
    chk("amid_box_x", 32'(dut.box_x), 32'd0);
    chk("amid_box_y", 32'(dut.box_y), 32'd0);
    chk("amid_color", 32'(dut.color_idx), 32'd0);
    model_reset();
    sb_q.delete();
    vif.HSync = 1'b1;
    vif.VSync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 144, 35);
    step(1'b1, 1'b1, 1'b1, 1'b1, 176, 35);

    // Corner hit on the preloaded instance
    chk("cor_pre_x", 32'(dut_c.box_x), 32'd606);
    chk("cor_pre_y", 32'(dut_c.box_y), 32'd446);
    chk("cor_pre_color", 32'(dut_c.color_idx), 32'd0);
    run_c = 1'b1;
    vif_c.VSync = 1'b0;
    @(posedge clk); #1;
    run_c = 1'b0;
    vif_c.VSync = 1'b1;
    chk("cor_x", 32'(dut_c.box_x), 32'd608);
    chk("cor_y", 32'(dut_c.box_y), 32'd448);
    chk("cor_xdir", 32'(dut_c.u_x.state), 32'(DEC));
    chk("cor_ydir", 32'(dut_c.u_y.state), 32'(DEC));
    chk("cor_color", 32'(dut_c.color_idx), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("cor_hold_x", 32'(dut_c.box_x), 32'd608);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
